simple_bus_arb: RTL and testbench
=================================

SIMPLE_BUS_ARB -- requirements
Module: simple_bus_arb

Interface
REQ-001 Parameter NUM_M, default 4, number of masters (2..16).
REQ-002 Parameter ADDR_W, default 8, address width.
REQ-003 Parameter DATA_W, default 8, data width.
REQ-004 Parameter MODE_W, default 2, mode width; value forwarded opaquely to the slave.
REQ-005 Parameter TIMEOUT, default 16, maximum slave wait in cycles; 0 disables timeout.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 m_req  in  NUM_M  per-master bus request.
REQ-009 m_start  in  NUM_M  per-master transfer start strobe.
REQ-010 m_addr  in  NUM_M*ADDR_W  packed master addresses; master i at bits [i*ADDR_W +: ADDR_W].
REQ-011 m_mode  in  NUM_M*MODE_W  packed master modes.
REQ-012 m_wdata  in  NUM_M*DATA_W  packed master write data.
REQ-013 m_gnt  out  NUM_M  one-hot grant.
REQ-014 m_rdy  out  NUM_M  one-hot, one-cycle completion pulse.
REQ-015 m_rdata  out  DATA_W  read data; valid only while any m_rdy bit is 1.
REQ-016 m_err  out  1  timeout flag; valid only while any m_rdy bit is 1.
REQ-017 s_req  out  1  slave request; held for the whole slave phase.
REQ-018 s_start  out  1  one-cycle slave start pulse.
REQ-019 s_addr/s_mode/s_wdata  out  ADDR_W/MODE_W/DATA_W  latched transfer fields.
REQ-020 s_rdy  in  1  slave completion; s_rdata sampled in the same cycle.
REQ-021 s_rdata  in  DATA_W  slave read data.
REQ-022 busy  out  1  high whenever the state is not IDLE.

Function
REQ-023 FSM states: IDLE, GRANT, WAIT, DONE; all outputs registered.
REQ-024 IDLE: if m_req is nonzero, the winner is the first requesting index searched from (last+1) mod NUM_M upward with wrap; m_gnt[winner]=1 from the next cycle; go to GRANT; last := winner.
REQ-025 GRANT: m_gnt held; in the cycle m_start[winner]=1, latch that master's addr/mode/wdata; the next cycle s_req=1, s_start=1 for exactly that cycle; go to WAIT; reset timeout counter to 0.
REQ-026 GRANT: if m_req[winner]=0 before start, drop m_gnt next cycle and return to IDLE without a slave transfer; last stays = winner.
REQ-027 m_start from non-granted masters, and m_start[winner] outside GRANT, is ignored.
REQ-028 WAIT: s_req held at 1; counter increments each cycle s_rdy=0.
REQ-029 WAIT: on s_rdy=1, capture s_rdata; the next cycle go to DONE with m_rdy[winner]=1, m_rdata=captured data, m_err=0, s_req=0.
REQ-030 WAIT: if TIMEOUT>0 and the counter reaches TIMEOUT with s_rdy never seen, go to DONE with m_rdy[winner]=1, m_err=1, m_rdata=0, s_req=0.
REQ-031 If s_rdy arrives in the same cycle the counter reaches TIMEOUT, completion wins and m_err=0.
REQ-032 DONE lasts one cycle; m_gnt drops with it; return to IDLE; earliest next grant is 2 cycles after the m_rdy pulse.
REQ-033 s_rdy outside WAIT is ignored.
REQ-034 Minimum latency: req at cycle 0 gives gnt at 1; start at 1 gives s_start at 2; s_rdy at 2 gives m_rdy at 3.
REQ-035 Counter width is clog2(TIMEOUT+1), minimum 1 bit; it never wraps.
REQ-036 m_gnt and m_rdy are never multi-hot; s_start is never high outside the first WAIT cycle.

Reset
REQ-037 While rst_n=0 at a clock edge: state=IDLE, last=NUM_M-1 (so index 0 wins first), m_gnt=0, m_rdy=0, m_err=0, m_rdata=0, s_req=0, s_start=0, s_addr/s_mode/s_wdata=0, busy=0, counter=0.
REQ-038 Reset asserted mid-transfer aborts it with no m_rdy pulse; the slave sees s_req drop after the reset edge.

Verification
REQ-039 NUM_M=4, out of reset, m_req=4'b1010 -> m_gnt=4'b0010 one cycle later; after its transfer completes, with m_req still 4'b1010 -> next grant is 4'b1000.
REQ-040 Master 2 granted, start with addr=8'h5A, mode=2'b01, wdata=8'hC3 -> s_start pulse with s_addr=8'h5A, s_mode=2'b01, s_wdata=8'hC3; s_rdy with s_rdata=8'h7E 3 cycles later -> m_rdy=4'b0100, m_rdata=8'h7E, m_err=0 one cycle later.
REQ-041 TIMEOUT=16, s_rdy never asserted -> m_rdy pulse with m_err=1 and m_rdata=0 exactly 16 cycles after the s_start cycle; s_req then 0.
REQ-042 Granted master drops m_req before start -> m_gnt=0 next cycle, no s_start, busy=0; remaining requester granted afterwards.
REQ-043 rst_n=0 during WAIT -> all outputs at reset values at the next edge, no m_rdy; after release, m_req=4'b1111 -> m_gnt=4'b0001.
REQ-044 s_rdy and counter==TIMEOUT in the same cycle -> m_err=0 and m_rdata=s_rdata.

Source files
------------

// File: rtl/simple_bus_arb.sv
// Round-robin arbiter granting one of NUM_M masters access to a single slave,
// with registered outputs, latched transfer fields and an optional slave timeout.
module simple_bus_arb #(
  parameter int NUM_M   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MODE_W  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_M-1:0]         m_req,
  input  logic [NUM_M-1:0]         m_start,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M*MODE_W-1:0]  m_mode,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  output logic [NUM_M-1:0]         m_gnt,
  output logic [NUM_M-1:0]         m_rdy,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_err,
  output logic                     s_req,
  output logic                     s_start,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [MODE_W-1:0]        s_mode,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_rdy,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic                     busy
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_M - 1);
  // Timeout fires on the last waiting cycle, as the counter steps onto TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_M-1:0]    gnt_q, gnt_d;
  logic [NUM_M-1:0]    rdy_q, rdy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                sreq_q, sreq_d;
  logic                sstart_q, sstart_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    win;
  logic                found;
  int unsigned         idx;

  // First requester after the last winner, wrapping around.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      idx = (32'(last_q) + i) % 32'(NUM_M);
      if (!found && m_req[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    rdy_d    = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    sreq_d   = sreq_q;
    sstart_d = 1'b0;
    addr_d   = addr_q;
    mode_d   = mode_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          last_d     = win;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!m_req[last_q]) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (m_start[last_q]) begin
          addr_d   = m_addr[last_q*ADDR_W +: ADDR_W];
          mode_d   = m_mode[last_q*MODE_W +: MODE_W];
          wdata_d  = m_wdata[last_q*DATA_W +: DATA_W];
          sreq_d   = 1'b1;
          sstart_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (s_rdy) begin
          rdy_d   = gnt_q;
          rdata_d = s_rdata;
          sreq_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
            rdy_d   = gnt_q;
            err_d   = 1'b1;
            sreq_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rdy_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sreq_q   <= 1'b0;
      sstart_q <= 1'b0;
      addr_q   <= '0;
      mode_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rdy_q    <= rdy_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sreq_q   <= sreq_d;
      sstart_q <= sstart_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign m_gnt   = gnt_q;
  assign m_rdy   = rdy_q;
  assign m_rdata = rdata_q;
  assign m_err   = err_q;
  assign s_req   = sreq_q;
  assign s_start = sstart_q;
  assign s_addr  = addr_q;
  assign s_mode  = mode_q;
  assign s_wdata = wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_simple_bus_arb.sv
// Directed bench for simple_bus_arb: stimulus pushes expected grants, slave
// starts and completions into queues; a negedge monitor pops and compares.
module tb_simple_bus_arb;
  localparam int NM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  m_req, m_start;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  m_mode;
  logic [3:0]  m_gnt, m_rdy;
  logic [7:0]  m_rdata;
  logic        m_err, s_req, s_start;
  logic [7:0]  s_addr, s_wdata;
  logic [1:0]  s_mode;
  logic        s_rdy;
  logic [7:0]  s_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_gnt[$];
  logic [17:0] exp_s[$];
  logic [12:0] exp_rdy[$];
  logic [3:0]  prev_gnt = '0;

  simple_bus_arb #(.NUM_M(NM), .ADDR_W(8), .DATA_W(8), .MODE_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_start(m_start), .m_addr(m_addr),
    .m_mode(m_mode), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rdy(m_rdy),
    .m_rdata(m_rdata), .m_err(m_err), .s_req(s_req), .s_start(s_start),
    .s_addr(s_addr), .s_mode(s_mode), .s_wdata(s_wdata), .s_rdy(s_rdy),
    .s_rdata(s_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_gnt != 4'b0 && prev_gnt == 4'b0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(m_gnt), 32'h0);
        else chk("gnt", 32'(m_gnt), 32'(exp_gnt.pop_front()));
      end
      if (s_start) begin
        if (exp_s.size() == 0) chk("s_start_unexpected", 32'(s_start), 32'h0);
        else chk("s_fields", 32'({s_addr, s_mode, s_wdata}), 32'(exp_s.pop_front()));
      end
      if (m_rdy != 4'b0) begin
        if (exp_rdy.size() == 0) chk("rdy_unexpected", 32'(m_rdy), 32'h0);
        else chk("rdy", 32'({m_rdy, m_rdata, m_err}), 32'(exp_rdy.pop_front()));
      end
    end
    prev_gnt = m_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i);
    int n = 0;
    while (!m_gnt[i] && n < 20) begin
      tick();
      n++;
    end
    chk("gnt_wait", 32'(m_gnt[i]), 32'h1);
  endtask

  task automatic start(input int i, input logic [7:0] a, input logic [1:0] md, input logic [7:0] wd);
    m_addr[i*8 +: 8]  = a;
    m_mode[i*2 +: 2]  = md;
    m_wdata[i*8 +: 8] = wd;
    m_start           = '0;
    m_start[i]        = 1'b1;
    tick();
    m_start = '0;
    chk("s_start_latency", 32'(s_start), 32'h1);
  endtask

  // Grant wait, start, then s_rdy after d cycles; returns one cycle after s_rdy.
  task automatic xfer(input int i, input logic [7:0] a, input logic [1:0] md,
                      input logic [7:0] wd, input int d, input logic [7:0] rd);
    wait_gnt(i);
    start(i, a, md, wd);
    repeat (d) tick();
    s_rdy   = 1'b1;
    s_rdata = rd;
    tick();
    s_rdy   = 1'b0;
    s_rdata = 8'h00;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 32'({m_gnt, m_rdy, m_err, m_rdata, s_req, s_start, busy}), 32'h0);
    chk({name, "_sfields"}, 32'({s_addr, s_mode, s_wdata}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; m_req = '0; m_start = '0; m_addr = '0; m_mode = '0; m_wdata = '0;
    s_rdy = 1'b0; s_rdata = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Round robin from reset: 1010 -> master 1, then master 3
    exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b1000);
    exp_s.push_back({8'h11, 2'd2, 8'h22}); exp_rdy.push_back({4'b0010, 8'h33, 1'b0});
    exp_s.push_back({8'h44, 2'd3, 8'h55}); exp_rdy.push_back({4'b1000, 8'h66, 1'b0});
    m_req = 4'b1010;
    tick();
    chk("gnt_latency", 32'(m_gnt), 32'h2);
    xfer(1, 8'h11, 2'd2, 8'h22, 0, 8'h33);
    tick();
    chk("idle_gap_gnt", 32'(m_gnt), 32'h0);
    chk("idle_gap_busy", 32'(busy), 32'h0);
    tick();
    chk("regrant_2cyc", 32'(m_gnt), 32'h8);
    xfer(3, 8'h44, 2'd3, 8'h55, 1, 8'h66);
    m_req = '0;
    repeat (2) tick();

    // Master 2 transfer with 3-cycle slave delay
    exp_gnt.push_back(4'b0100);
    exp_s.push_back({8'h5A, 2'b01, 8'hC3}); exp_rdy.push_back({4'b0100, 8'h7E, 1'b0});
    m_req = 4'b0100;
    xfer(2, 8'h5A, 2'b01, 8'hC3, 3, 8'h7E);
    m_req = '0;
    repeat (2) tick();
    s_rdy = 1'b1; s_rdata = 8'hBB;
    tick();
    s_rdy = 1'b0; s_rdata = 8'h00;
    tick();

    // Timeout on master 0: m_rdy exactly 16 cycles after s_start
    exp_gnt.push_back(4'b0001);
    exp_s.push_back({8'hA5, 2'd0, 8'h0F}); exp_rdy.push_back({4'b0001, 8'h00, 1'b1});
    m_req = 4'b0001;
    wait_gnt(0);
    s_rdata = 8'hAA;
    start(0, 8'hA5, 2'd0, 8'h0F);
    n = 0;
    while (m_rdy == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("timeout_sreq", 32'(s_req), 32'h0);
    s_rdata = 8'h00;
    m_req = '0;
    repeat (2) tick();

    // s_rdy on the final wait cycle beats the timeout
    exp_gnt.push_back(4'b0010);
    exp_s.push_back({8'h12, 2'd1, 8'h34}); exp_rdy.push_back({4'b0010, 8'h9D, 1'b0});
    m_req = 4'b0010;
    xfer(1, 8'h12, 2'd1, 8'h34, 15, 8'h9D);
    m_req = '0;
    repeat (2) tick();

    // s_rdy one cycle late: timeout already reported, late s_rdy ignored
    exp_gnt.push_back(4'b0100);
    exp_s.push_back({8'h21, 2'd2, 8'h43}); exp_rdy.push_back({4'b0100, 8'h00, 1'b1});
    m_req = 4'b0100;
    xfer(2, 8'h21, 2'd2, 8'h43, 16, 8'hEE);
    m_req = '0;
    repeat (2) tick();

    // Granted master 0 drops its request; master 1 follows; foreign start ignored
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010);
    exp_s.push_back({8'h77, 2'd3, 8'h88}); exp_rdy.push_back({4'b0010, 8'h11, 1'b0});
    m_req = 4'b0011;
    wait_gnt(0);
    m_req = 4'b0010;
    tick();
    chk("drop_gnt", 32'(m_gnt), 32'h0);
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_sreq", 32'(s_req), 32'h0);
    tick();
    chk("drop_next_gnt", 32'(m_gnt), 32'h2);
    m_start = 4'b1000;
    tick();
    m_start = '0;
    chk("foreign_start", 32'(s_start), 32'h0);
    xfer(1, 8'h77, 2'd3, 8'h88, 0, 8'h11);
    m_req = '0;
    repeat (2) tick();

    // Reset during WAIT aborts without m_rdy; then 1111 grants master 0
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b0001);
    exp_s.push_back({8'h99, 2'd0, 8'hAB});
    m_req = 4'b0100;
    wait_gnt(2);
    start(2, 8'h99, 2'd0, 8'hAB);
    tick();
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("mid_reset");
    rst_n = 1'b1;
    m_req = 4'b1111;
    tick();
    chk("post_reset_gnt", 32'(m_gnt), 32'h1);
    m_req = '0;
    repeat (4) tick();

    chk("exp_gnt_left", 32'(exp_gnt.size()), 32'h0);
    chk("exp_s_left", 32'(exp_s.size()), 32'h0);
    chk("exp_rdy_left", 32'(exp_rdy.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
